score_display_ctrl: RTL
=======================

Name: score_display_ctrl

Overview:
- Owns both player scores and time-shares a single seven-segment font renderer between the left and right score positions.
- Latches point events from the ball/collision logic and commits them at frame boundaries, so a digit never changes mid-frame.
- Encodes each score into the renderer's 7-bit segment vector and runs the game-over/blink/restart sequence.
- Sits between the game logic and the font renderer, alongside the VGA timing generator.

Parameters:
- WIN_SCORE, 9, score that ends the game (1..9).
- LEFT_X, 10'd280, font_x of the left digit.
- RIGHT_X, 10'd336, font_x of the right digit.
- SCORE_Y, 10'd16, font_y of both digits.
- MID_X, 10'd320, pixel_x split: below it the left digit is drawn, at or above it the right digit.
- BLINK_FRAMES, 16, frames per blink half-period in GAME_OVER.
- OVER_FRAMES, 180, frames GAME_OVER lasts before auto-restart.

Ports:
- i_clk  in  1  pixel clock
- i_reset  in  1  asynchronous, active-high reset
- i_frame_start  in  1  one-cycle pulse at the start of vertical blank
- i_pixel_x  in  10  current pixel column
- i_point_left  in  1  pulse: left player scored (any cycle, any width)
- i_point_right  in  1  pulse: right player scored
- i_restart  in  1  level: request restart from GAME_OVER
- o_score_left  out  4  committed left score
- o_score_right  out  4  committed right score
- o_game_over  out  1  high in GAME_OVER
- o_winner  out  1  0 = left won, 1 = right won; valid while o_game_over
- o_font_x  out  10  to renderer
- o_font_y  out  10  to renderer
- o_digit  out  7  segment vector to renderer

Behaviour:
- Reset (async): scores 0; pending flags 0; state PLAY; frame/blink counters 0; o_game_over 0; o_winner 0; segment registers hold the code for 0 (7'h77).
- Segment bit map: 0 top, 1 upper-left, 2 upper-right, 3 middle, 4 lower-left, 5 lower-right, 6 bottom.
- Digit codes 0..9: 77,24,5D,6D,2E,6B,7B,25,7F,6F (hex). Values above 9 encode to 00 (blank).
- pend_left/pend_right: set on the rising clock edge where the point input is high while in PLAY; cleared on commit. Several pulses within one frame count once.
- On i_frame_start in PLAY:
  - Each side with a pending flag increments by 1, saturating at WIN_SCORE. Both sides commit in the same cycle when both are pending.
  - Segment registers update in the same cycle, so the new codes are visible from the next clock.
  - A point input high in that same cycle is captured into pending for the next frame.
  - If either new score equals WIN_SCORE: state becomes GAME_OVER, o_game_over=1, o_winner=(right reached it).
  - If both reach WIN_SCORE on one commit, the left side wins.
- GAME_OVER:
  - Point inputs are ignored and pending flags are held at 0.
  - The frame counter increments on each i_frame_start.
  - Blink phase toggles every BLINK_FRAMES frames. During the off phase, the winner's o_digit is forced to 0.
  - Exit when the counter reaches OVER_FRAMES, or at the first i_frame_start that sees i_restart high.
  - On exit: state RESTART.
- RESTART: lasts exactly until the next i_frame_start, at which scores clear to 0, counters clear, o_game_over=0, and state returns to PLAY.
- Renderer mux (combinational from i_pixel_x and registered state):
  - i_pixel_x < MID_X: o_font_x=LEFT_X, o_digit=left code.
  - Otherwise: o_font_x=RIGHT_X, o_digit=right code.
  - o_font_y=SCORE_Y always.
- Widths: scores are 4 bits; frame counter is 8 bits; comparisons are unsigned.

Decomposition:
- Shared package: state encoding (PLAY, GAME_OVER, RESTART), the ten segment-code constants, and the segment bit-index names.
- Sub-module seg7_encode (4-bit value to 7-bit code), instantiated twice.

Test Plan:
- Reset state: hold i_reset → scores 0, o_game_over 0. i_pixel_x=100 → o_digit=7'h77, o_font_x=280. i_pixel_x=400 → o_font_x=336.
- Commit timing: one i_point_left pulse mid-frame → o_score_left stays 0 until i_frame_start, then 1 and o_digit=7'h24 on the left half. Three left pulses in one frame → score +1 only.
- Both sides: both point inputs in the same frame → both scores increment on one i_frame_start. Left=8, right=8, both score → GAME_OVER with o_winner=0.
- Win and blink: right reaches 9 → o_game_over=1, o_winner=1. The right digit alternates 6F/00 every 16 frames. Points are ignored; scores hold at the final values.
- Restart: i_restart high during GAME_OVER → next frame RESTART, following frame scores 0 and o_game_over=0. With no restart, auto-exit after 180 frames.
- Async reset mid-GAME_OVER: scores clear immediately, without a clock edge, and play resumes normally.

Source files
------------

// File: rtl/score_display_ctrl_pkg.sv
// score_display_ctrl_pkg: shared state encoding and seven-segment constants
package score_display_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_GAME_OVER = 2'd1,
    ST_RESTART   = 2'd2
  } state_t;
  localparam int SEG_TOP = 0;
  localparam int SEG_UL  = 1;
  localparam int SEG_UR  = 2;
  localparam int SEG_MID = 3;
  localparam int SEG_LL  = 4;
  localparam int SEG_LR  = 5;
  localparam int SEG_BOT = 6;
  localparam logic [6:0] SEG_0     = 7'h77;
  localparam logic [6:0] SEG_1     = 7'h24;
  localparam logic [6:0] SEG_2     = 7'h5D;
  localparam logic [6:0] SEG_3     = 7'h6D;
  localparam logic [6:0] SEG_4     = 7'h2E;
  localparam logic [6:0] SEG_5     = 7'h6B;
  localparam logic [6:0] SEG_6     = 7'h7B;
  localparam logic [6:0] SEG_7     = 7'h25;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
endpackage

// File: rtl/score_display_ctrl_seg7_encode.sv
// seg7_encode: 4-bit value to 7-bit segment vector, blank above 9
module seg7_encode
  import score_display_ctrl_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] code
);
  always_comb begin
    code = SEG_BLANK;
    case (value)
      4'd0: code = SEG_0;
      4'd1: code = SEG_1;
      4'd2: code = SEG_2;
      4'd3: code = SEG_3;
      4'd4: code = SEG_4;
      4'd5: code = SEG_5;
      4'd6: code = SEG_6;
      4'd7: code = SEG_7;
      4'd8: code = SEG_8;
      4'd9: code = SEG_9;
      default: code = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/score_display_ctrl.sv
// score_display_ctrl: frame-synchronous score keeping, game-over sequencing and score digit mux
module score_display_ctrl
  import score_display_ctrl_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 9,
  parameter logic [9:0]  LEFT_X       = 10'd280,
  parameter logic [9:0]  RIGHT_X      = 10'd336,
  parameter logic [9:0]  SCORE_Y      = 10'd16,
  parameter logic [9:0]  MID_X        = 10'd320,
  parameter int unsigned BLINK_FRAMES = 16,
  parameter int unsigned OVER_FRAMES  = 180
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_frame_start,
  input  logic [9:0] i_pixel_x,
  input  logic       i_point_left,
  input  logic       i_point_right,
  input  logic       i_restart,
  output logic [3:0] o_score_left,
  output logic [3:0] o_score_right,
  output logic       o_game_over,
  output logic       o_winner,
  output logic [9:0] o_font_x,
  output logic [9:0] o_font_y,
  output logic [6:0] o_digit
);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  state_t state;
  logic pend_l, pend_r, blink_off, commit, clear, win_l, win_r, game_end, blank_l, blank_r;
  logic [3:0] nxt_l, nxt_r;
  logic [7:0] frame_cnt, blink_cnt;
  logic [6:0] seg_l, seg_r, enc_l, enc_r;
  always_comb begin
    commit   = state == ST_PLAY && i_frame_start;
    clear    = state == ST_RESTART && i_frame_start;
    nxt_l    = clear ? 4'd0 : (commit && pend_l && o_score_left < WIN) ? o_score_left + 4'd1 : o_score_left;
    nxt_r    = clear ? 4'd0 : (commit && pend_r && o_score_right < WIN) ? o_score_right + 4'd1 : o_score_right;
    win_l    = nxt_l == WIN;
    win_r    = nxt_r == WIN;
    game_end = commit && (win_l || win_r);
    blank_l  = state == ST_GAME_OVER && blink_off && !o_winner;
    blank_r  = state == ST_GAME_OVER && blink_off && o_winner;
    o_font_x = i_pixel_x < MID_X ? LEFT_X : RIGHT_X;
    o_font_y = SCORE_Y;
    o_digit  = i_pixel_x < MID_X ? (blank_l ? SEG_BLANK : seg_l) : (blank_r ? SEG_BLANK : seg_r);
  end
  seg7_encode u_enc_l (.value(nxt_l), .code(enc_l));
  seg7_encode u_enc_r (.value(nxt_r), .code(enc_r));
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= ST_PLAY;
      o_score_left  <= 4'd0;
      o_score_right <= 4'd0;
      pend_l        <= 1'b0;
      pend_r        <= 1'b0;
      frame_cnt     <= 8'd0;
      blink_cnt     <= 8'd0;
      blink_off     <= 1'b0;
      o_game_over   <= 1'b0;
      o_winner      <= 1'b0;
      seg_l         <= SEG_0;
      seg_r         <= SEG_0;
    end else begin
      o_score_left  <= nxt_l;
      o_score_right <= nxt_r;
      seg_l         <= enc_l;
      seg_r         <= enc_r;
      // a point arriving on the commit cycle itself is kept for the next frame
      pend_l <= state == ST_PLAY && !game_end && (i_point_left || (pend_l && !commit));
      pend_r <= state == ST_PLAY && !game_end && (i_point_right || (pend_r && !commit));
      case (state)
        ST_PLAY: if (game_end) begin
          state       <= ST_GAME_OVER;
          o_game_over <= 1'b1;
          o_winner    <= !win_l;
        end
        ST_GAME_OVER: if (i_frame_start) begin
          frame_cnt <= frame_cnt + 8'd1;
          blink_cnt <= blink_cnt == 8'(BLINK_FRAMES - 1) ? 8'd0 : blink_cnt + 8'd1;
          blink_off <= blink_cnt == 8'(BLINK_FRAMES - 1) ? !blink_off : blink_off;
          if (i_restart || frame_cnt == 8'(OVER_FRAMES - 1)) state <= ST_RESTART;
        end
        ST_RESTART: if (i_frame_start) begin
          state       <= ST_PLAY;
          o_game_over <= 1'b0;
          frame_cnt   <= 8'd0;
          blink_cnt   <= 8'd0;
          blink_off   <= 1'b0;
        end
        default: state <= ST_PLAY;
      endcase
    end
  end
endmodule
